packet_tx_arbiter: RTL and testbench
====================================

# packet_tx_arbiter

Transmit-side counterpart of the UART packet receiver. Shares the single byte-wide UART transmit link between three requesters: DMA tile write, DMA tile read request, and program-done notification. Grants one requester at a time round-robin, serializes its packet as a header byte plus big-endian payload, and meters read requests against a credit limit replenished by read-result completions from the receiver.

## Interface
- MAX_OUTSTANDING_READS, 4, maximum read requests granted but not yet answered by a read-result packet (1..63).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- mem_write_valid  in  1  write request pending; addr/tile held stable until ready.
- mem_write_ready  out  1  one-cycle grant pulse; payload latched this cycle.
- mem_write_addr  in  16  tile address.
- mem_write_tile  in  288  4x4x18-bit tile, bits [287:280] transmitted first.
- mem_read_valid  in  1  read request pending.
- mem_read_ready  out  1  one-cycle grant pulse.
- mem_read_addr  in  16  tile address.
- prog_done_valid  in  1  program-done notification pending.
- prog_done_ready  out  1  one-cycle grant pulse.
- prog_done_id  in  8  id of finished program.
- mem_read_result_stb  in  1  one-cycle pulse from receiver: one read result fully received.
- tx_stb  out  1  tx_data valid.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  UART accepts byte; transfer occurs on cycle with tx_stb && tx_ready.
- busy  out  1  high in any state other than IDLE.
- outstanding_reads  out  6  current read credit usage.
- credit_error  out  1  sticky: result strobe arrived with outstanding_reads == 0.

## Operation
- Header byte = {length[5:0], type[1:0]}; length = payload bytes. Types: 1 = program done (length 1: id), 2 = read request (length 2: addr[15:8], addr[7:0]), 3 = tile write (length 38: addr hi, addr lo, then 36 tile bytes MSB first). Type 0 never sent.
- States: IDLE, HEADER, PAYLOAD.
- IDLE: eligible set = valid requesters, with read excluded when outstanding_reads == MAX_OUTSTANDING_READS. If non-empty: pick first eligible starting at rr pointer in order write(0) -> read(1) -> done(2) -> wrap; pulse its ready; load header and payload into 39-byte shift register, byte counter = length; rr pointer = granted index + 1 mod 3; go HEADER. Empty: stay, no ready.
- HEADER: tx_stb=1, tx_data=header. On transfer: go PAYLOAD.
- PAYLOAD: tx_stb=1, tx_data=top payload byte. On transfer: shift left 8, decrement counter; transfer of last byte -> IDLE with tx_stb=0 next cycle.
- tx_data/tx_stb held unchanged while tx_ready low; no byte dropped or repeated.
- Credit: +1 on read grant, -1 on mem_read_result_stb; both same cycle -> unchanged. Strobe at 0 -> stays 0, credit_error set. Strobes accepted in every state.
- Requester deasserting valid before grant is legal; never granted.

## Timing
- Reset values: tx_stb 0, tx_data 0, all readies 0, busy 0, outstanding_reads 0, credit_error 0, rr pointer 0, state IDLE.
- Grant latency: ready asserted in first IDLE cycle with eligible valid (combinational on valid; registered state).
- Header on tx_data cycle after grant. With tx_ready held high, packet of N payload bytes occupies 1 grant cycle + N+1 transfer cycles; one idle bubble between back-to-back packets.
- Reset mid-packet: abort, IDLE next cycle, tx_stb 0, credits cleared; unsent bytes lost; held requests re-arbitrated.
- Read credit reaching max mid-IDLE takes effect same cycle (counter value at that cycle's start).

## Test plan
- Single read, addr 0x12AB, tx_ready high -> read_ready pulse, bytes 0x0A, 0x12, 0xAB; outstanding_reads 1.
- Write addr 0x0004, tile = 288-bit count pattern, tx_ready toggling 1/0 -> header 0x9B, 0x00, 0x04, 36 tile bytes MSB first, data stable during stalls.
- All three valid continuously from reset -> grant order write, read, done, write, ...; done packet 0x05, id.
- MAX=4, five reads, no results -> four grants, fifth waits; one result strobe -> fifth granted next IDLE.
- Result strobe same cycle as read grant at count 2 -> count stays 2; strobe at count 0 -> credit_error 1, count 0.
- Reset during byte 10 of write packet -> tx_stb 0 next cycle, IDLE, counters 0; held write re-sent in full.

Source files
------------

// File: rtl/packet_tx_arbiter.sv
// packet_tx_arbiter: round-robin arbiter that shares one byte-wide UART transmit
// link between tile writes, read requests and program-done notifications.
// Each grant is sent as a header byte {length, type} and a big-endian payload.
// Read requests are limited by a credit count that read-result strobes return.
module packet_tx_arbiter #(
    parameter int MAX_OUTSTANDING_READS = 4
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         mem_write_valid,
    output logic         mem_write_ready,
    input  logic [15:0]  mem_write_addr,
    input  logic [287:0] mem_write_tile,

    input  logic         mem_read_valid,
    output logic         mem_read_ready,
    input  logic [15:0]  mem_read_addr,

    input  logic         prog_done_valid,
    output logic         prog_done_ready,
    input  logic [7:0]   prog_done_id,

    input  logic         mem_read_result_stb,

    output logic         tx_stb,
    output logic [7:0]   tx_data,
    input  logic         tx_ready,

    output logic         busy,
    output logic [5:0]   outstanding_reads,
    output logic         credit_error
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    localparam logic [5:0] MAX_READS = 6'(MAX_OUTSTANDING_READS);

    // Header byte = {payload length, packet type}.
    localparam logic [7:0] HDR_DONE  = {6'd1,  2'd1};
    localparam logic [7:0] HDR_READ  = {6'd2,  2'd2};
    localparam logic [7:0] HDR_WRITE = {6'd38, 2'd3};

    // Header plus the longest payload (38 bytes) = 39 bytes.
    localparam int SHIFT_W = 312;

    logic [1:0]         state_q, state_d;
    logic [1:0]         rr_q, rr_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [5:0]         count_q, count_d;
    logic [5:0]         outstanding_q, outstanding_d;
    logic               credit_error_q, credit_error_d;

    logic [2:0] eligible;
    logic [2:0] grant;
    logic       tx_fire;

    // Pick the first eligible requester starting at the round-robin pointer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        grant    = 3'b000;
        eligible = {prog_done_valid,
                    mem_read_valid && (outstanding_q != MAX_READS),
                    mem_write_valid};
        if (state_q == ST_IDLE && !reset) begin
            case (rr_q)
                2'd1: begin
                    if      (eligible[1]) grant = 3'b010;
                    else if (eligible[2]) grant = 3'b100;
                    else if (eligible[0]) grant = 3'b001;
                end
                2'd2: begin
                    if      (eligible[2]) grant = 3'b100;
                    else if (eligible[0]) grant = 3'b001;
                    else if (eligible[1]) grant = 3'b010;
                end
                default: begin
                    if      (eligible[0]) grant = 3'b001;
                    else if (eligible[1]) grant = 3'b010;
                    else if (eligible[2]) grant = 3'b100;
                end
            endcase
        end
    end

    assign mem_write_ready = grant[0];
    assign mem_read_ready  = grant[1];
    assign prog_done_ready = grant[2];

    assign busy              = (state_q != ST_IDLE);
    assign tx_stb            = busy;
    assign tx_data           = busy ? shift_q[SHIFT_W-1 -: 8] : 8'h00;
    assign tx_fire           = tx_stb && tx_ready;
    assign outstanding_reads = outstanding_q;
    assign credit_error      = credit_error_q;

    // Packet sequencing: load on grant, shift one byte out per accepted transfer.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        shift_d = shift_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (grant[0]) begin
                    shift_d = {HDR_WRITE, mem_write_addr, mem_write_tile};
                    count_d = 6'd38;
                    rr_d    = 2'd1;
                    state_d = ST_HEADER;
                end else if (grant[1]) begin
                    shift_d = {HDR_READ, mem_read_addr, 288'd0};
                    count_d = 6'd2;
                    rr_d    = 2'd2;
                    state_d = ST_HEADER;
                end else if (grant[2]) begin
                    shift_d = {HDR_DONE, prog_done_id, 296'd0};
                    count_d = 6'd1;
                    rr_d    = 2'd0;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (tx_fire) begin
                    shift_d = {shift_q[SHIFT_W-9:0], 8'h00};
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (tx_fire) begin
                    shift_d = {shift_q[SHIFT_W-9:0], 8'h00};
                    count_d = count_q - 6'd1;
                    if (count_q == 6'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read credit: grants consume, result strobes return; a strobe at zero is an error and is ignored.
    always_comb begin
        outstanding_d  = outstanding_q;
        credit_error_d = credit_error_q;
        if (mem_read_result_stb && outstanding_q == 6'd0) begin
            credit_error_d = 1'b1;
            if (grant[1]) outstanding_d = outstanding_q + 6'd1;
        end else if (grant[1] && !mem_read_result_stb) begin
            outstanding_d = outstanding_q + 6'd1;
        end else if (mem_read_result_stb && !grant[1]) begin
            outstanding_d = outstanding_q - 6'd1;
        end
    end

    // State registers with synchronous reset; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q        <= ST_IDLE;
            rr_q           <= 2'd0;
            shift_q        <= '0;
            count_q        <= 6'd0;
            outstanding_q  <= 6'd0;
            credit_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            shift_q        <= shift_d;
            count_q        <= count_d;
            outstanding_q  <= outstanding_d;
            credit_error_q <= credit_error_d;
        end
    end

endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Directed bench for packet_tx_arbiter: a per-cycle vector table for reads,
// done packets and credit accounting, then hand sequences for the tile write
// with stalls, round-robin order, credit limit, and reset mid-packet.
module tb_packet_tx_arbiter;

    logic         clk;
    logic         reset;
    logic         mem_write_valid;
    logic         mem_write_ready;
    logic [15:0]  mem_write_addr;
    logic [287:0] mem_write_tile;
    logic         mem_read_valid;
    logic         mem_read_ready;
    logic [15:0]  mem_read_addr;
    logic         prog_done_valid;
    logic         prog_done_ready;
    logic [7:0]   prog_done_id;
    logic         mem_read_result_stb;
    logic         tx_stb;
    logic [7:0]   tx_data;
    logic         tx_ready;
    logic         busy;
    logic [5:0]   outstanding_reads;
    logic         credit_error;

    int n_vec = 0;
    int n_err = 0;

    packet_tx_arbiter #(.MAX_OUTSTANDING_READS(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_write_valid     (mem_write_valid),
        .mem_write_ready     (mem_write_ready),
        .mem_write_addr      (mem_write_addr),
        .mem_write_tile      (mem_write_tile),
        .mem_read_valid      (mem_read_valid),
        .mem_read_ready      (mem_read_ready),
        .mem_read_addr       (mem_read_addr),
        .prog_done_valid     (prog_done_valid),
        .prog_done_ready     (prog_done_ready),
        .prog_done_id        (prog_done_id),
        .mem_read_result_stb (mem_read_result_stb),
        .tx_stb              (tx_stb),
        .tx_data             (tx_data),
        .tx_ready            (tx_ready),
        .busy                (busy),
        .outstanding_reads   (outstanding_reads),
        .credit_error        (credit_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, wv, rv, dv, rstb, txr;
        logic [15:0] raddr;
        logic [7:0]  did;
        logic        wr, rr, dr, stb;
        logic [7:0]  data;
        logic        bsy;
        logic [5:0]  outs;
        logic        cerr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic rst, wv, rv, dv, rstb, txr,
                                input logic [15:0] raddr, input logic [7:0] did,
                                input logic wr, rr, dr, stb, input logic [7:0] data,
                                input logic bsy, input logic [5:0] outs, input logic cerr);
        vec_t v;
        v.rst = rst; v.wv = wv; v.rv = rv; v.dv = dv; v.rstb = rstb; v.txr = txr;
        v.raddr = raddr; v.did = did;
        v.wr = wr; v.rr = rr; v.dr = dr; v.stb = stb; v.data = data;
        v.bsy = bsy; v.outs = outs; v.cerr = cerr;
        vecs.push_back(v);
    endfunction

    // Expected byte i of the write packet for addr 0x0004 and the count-pattern tile.
    function automatic logic [7:0] exp_wbyte(input int i);
        if (i == 0) return 8'h9B;
        if (i == 1) return 8'h00;
        if (i == 2) return 8'h04;
        return 8'(i - 2);
    endfunction

    task automatic idle_inputs();
        mem_write_valid     = 1'b0;
        mem_read_valid      = 1'b0;
        prog_done_valid     = 1'b0;
        mem_read_result_stb = 1'b0;
        tx_ready            = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Receive one full write packet starting at the current (header) cycle.
    task automatic recv_write(input bit toggle, input string tag);
        int idx = 0;
        int cyc = 0;
        bit r = 1'b1;
        while (idx < 39 && cyc < 200) begin
            tx_ready = r;
            #1;
            check({tag, " stb"}, tx_stb, 1);
            check({tag, " data"}, tx_data, exp_wbyte(idx));
            if (r) idx++;
            @(negedge clk);
            cyc++;
            if (toggle) r = !r;
        end
        check({tag, " byte count"}, idx, 39);
        tx_ready = 1'b1;
        #1;
        check({tag, " stb after"}, tx_stb, 0);
        check({tag, " busy after"}, busy, 0);
    endtask

    initial begin
        logic [2:0] exp_order [6];
        int ng;
        int dphase;
        int nreads;

        reset          = 1'b1;
        mem_write_addr = 16'h0004;
        mem_read_addr  = 16'h0000;
        prog_done_id   = 8'h00;
        mem_write_tile = '0;
        for (int i = 0; i < 36; i++) mem_write_tile[287 - 8*i -: 8] = 8'(i + 1);
        idle_inputs();

        //   rst wv rv dv stb txr raddr     did     wr rr dr stb data  bsy outs cerr
        add(1, 0, 1, 0, 0, 1, 16'h0000, 8'h00,  0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 16'h12AB, 8'h00,  0, 1, 0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00,  0, 0, 0, 1, 8'h0A, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00,  0, 0, 0, 1, 8'h12, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00,  0, 0, 0, 1, 8'hAB, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00,  0, 0, 0, 0, 8'h00, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 16'h0000, 8'h5A,  0, 0, 1, 0, 8'h00, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00,  0, 0, 0, 1, 8'h05, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00,  0, 0, 0, 1, 8'h5A, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00,  0, 0, 0, 1, 8'h5A, 1, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00,  0, 0, 0, 1, 8'h5A, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 16'h0000, 8'h00,  0, 0, 0, 0, 8'h00, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 16'h0000, 8'h00,  0, 0, 0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 8'h00,  0, 0, 0, 0, 8'h00, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1, 16'h0001, 8'h00,  0, 1, 0, 0, 8'h00, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0001, 8'h00,  0, 0, 0, 1, 8'h0A, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0001, 8'h00,  0, 0, 0, 1, 8'h00, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0001, 8'h00,  0, 0, 0, 1, 8'h01, 1, 1, 1);
        add(0, 0, 1, 0, 0, 1, 16'h0001, 8'h00,  0, 1, 0, 0, 8'h00, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0001, 8'h00,  0, 0, 0, 1, 8'h0A, 1, 2, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0001, 8'h00,  0, 0, 0, 1, 8'h00, 1, 2, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0001, 8'h00,  0, 0, 0, 1, 8'h01, 1, 2, 1);
        add(0, 0, 1, 0, 1, 1, 16'h0001, 8'h00,  0, 1, 0, 0, 8'h00, 0, 2, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0001, 8'h00,  0, 0, 0, 1, 8'h0A, 1, 2, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0001, 8'h00,  0, 0, 0, 1, 8'h00, 1, 2, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0001, 8'h00,  0, 0, 0, 1, 8'h01, 1, 2, 1);
        add(0, 0, 0, 0, 0, 1, 16'h0001, 8'h00,  0, 0, 0, 0, 8'h00, 0, 2, 1);

        // Table: one row per cycle, inputs driven at negedge, outputs checked 1 ns later.
        @(negedge clk);
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            reset               = vecs[i].rst;
            mem_write_valid     = vecs[i].wv;
            mem_read_valid      = vecs[i].rv;
            prog_done_valid     = vecs[i].dv;
            mem_read_result_stb = vecs[i].rstb;
            tx_ready            = vecs[i].txr;
            mem_read_addr       = vecs[i].raddr;
            prog_done_id        = vecs[i].did;
            #1;
            check($sformatf("row%0d write_ready", i), mem_write_ready, vecs[i].wr);
            check($sformatf("row%0d read_ready", i), mem_read_ready, vecs[i].rr);
            check($sformatf("row%0d done_ready", i), prog_done_ready, vecs[i].dr);
            check($sformatf("row%0d tx_stb", i), tx_stb, vecs[i].stb);
            check($sformatf("row%0d tx_data", i), tx_data, vecs[i].data);
            check($sformatf("row%0d busy", i), busy, vecs[i].bsy);
            check($sformatf("row%0d outstanding", i), outstanding_reads, vecs[i].outs);
            check($sformatf("row%0d credit_error", i), credit_error, vecs[i].cerr);
            @(negedge clk);
        end

        // Tile write with tx_ready toggling: bytes in order, held during stalls.
        do_reset();
        mem_write_valid = 1'b1;
        #1;
        check("write grant", mem_write_ready, 1);
        @(negedge clk);
        mem_write_valid = 1'b0;
        recv_write(1'b1, "write stall");

        // All three requesters valid from reset: write, read, done, write, read, done.
        do_reset();
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        mem_write_valid = 1'b1;
        mem_read_valid  = 1'b1;
        prog_done_valid = 1'b1;
        mem_read_addr   = 16'hBEEF;
        prog_done_id    = 8'h3C;
        ng     = 0;
        dphase = 0;
        for (int cyc = 0; cyc < 400 && ng < 6; cyc++) begin
            #1;
            if (dphase == 1) begin
                check("done header", tx_data, 8'h05);
                dphase = 2;
            end else if (dphase == 2) begin
                check("done id", tx_data, 8'h3C);
                dphase = 0;
            end
            if ({prog_done_ready, mem_read_ready, mem_write_ready} != 3'b000) begin
                check($sformatf("rr grant %0d", ng),
                      {prog_done_ready, mem_read_ready, mem_write_ready}, exp_order[ng]);
                if (prog_done_ready) dphase = 1;
                ng++;
            end
            @(negedge clk);
        end
        check("rr grant count", ng, 6);
        idle_inputs();

        // Credit limit: five reads wanted, four granted; one result frees the fifth.
        do_reset();
        mem_read_valid = 1'b1;
        mem_read_addr  = 16'h0100;
        nreads = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            #1;
            if (mem_read_ready) nreads++;
            @(negedge clk);
        end
        check("reads granted at limit", nreads, 4);
        mem_read_result_stb = 1'b1;
        #1;
        check("limit blocks read", mem_read_ready, 0);
        check("limit outstanding", outstanding_reads, 4);
        check("limit busy", busy, 0);
        @(negedge clk);
        mem_read_result_stb = 1'b0;
        #1;
        check("fifth read granted", mem_read_ready, 1);
        check("after result outstanding", outstanding_reads, 3);
        @(negedge clk);
        mem_read_valid = 1'b0;
        #1;
        check("fifth read outstanding", outstanding_reads, 4);
        repeat (3) @(negedge clk);

        // Reset during byte 10 of a write packet; held write is re-sent in full.
        do_reset();
        mem_read_valid = 1'b1;
        #1;
        check("pre-read grant", mem_read_ready, 1);
        @(negedge clk);
        mem_read_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("pre-read outstanding", outstanding_reads, 1);
        mem_write_valid = 1'b1;
        #1;
        check("abort write grant", mem_write_ready, 1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("abort byte %0d", i), tx_data, exp_wbyte(i));
            if (i == 9) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check("abort tx_stb", tx_stb, 0);
        check("abort busy", busy, 0);
        check("abort outstanding", outstanding_reads, 0);
        check("abort regrant", mem_write_ready, 1);
        @(negedge clk);
        mem_write_valid = 1'b0;
        recv_write(1'b0, "resend");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
